// File: rtl/proj_pkg.sv
// proj_pkg: shared definitions for the projection collapser.
//   - one-hot codes for the four packed base values
//   - k-mer index offset helper
//   - collapser FSM state type
package proj_pkg;

  // One-hot code per packed base value (base value n -> bit n set).
  localparam logic [3:0] OH_BASE_0 = 4'b0001;
  localparam logic [3:0] OH_BASE_1 = 4'b0010;
  localparam logic [3:0] OH_BASE_2 = 4'b0100;
  localparam logic [3:0] OH_BASE_3 = 4'b1000;

  typedef enum logic {
    S_FILL  = 1'b0,
    S_CHECK = 1'b1
  } collapser_state_t;

  // Offset that the extender subtracted when it made the index signed.
  function automatic int unsigned kmer_offset(input int unsigned frag_size,
                                              input int unsigned kmer_size);
    return (frag_size - kmer_size) >> 1;
  endfunction

endpackage

// File: rtl/gfm_base_decoder.sv
// gfm_base_decoder: combinational one-hot to packed base decoder.
//   gfm_i     : BASES one-hot slices of 4 bits, base 0 in the LSBs
//   bases_o   : BASES packed 2-bit bases, base 0 in the LSBs
//   invalid_o : high if any slice is not a legal one-hot code
// Illegal codes decode to 2'b00.
module gfm_base_decoder
  import proj_pkg::*;
#(
  parameter int unsigned BASES = 1
) (
  input  logic [4*BASES-1:0] gfm_i,
  output logic [2*BASES-1:0] bases_o,
  output logic               invalid_o
);

  logic [BASES-1:0] bad;

  for (genvar g = 0; g < BASES; g++) begin : g_base
    logic [1:0] code;
    logic       err;

    always_comb begin
      code = '0;
      err  = 1'b0;
      case (gfm_i[4*g +: 4])
        OH_BASE_0: code = 2'd0;
        OH_BASE_1: code = 2'd1;
        OH_BASE_2: code = 2'd2;
        OH_BASE_3: code = 2'd3;
        default:   err  = 1'b1;
      endcase
    end

    assign bases_o[2*g +: 2] = code;
    assign bad[g]            = err;
  end

  assign invalid_o = |bad;

endmodule

// File: rtl/proj_collapser.sv
// proj_collapser: rebuilds a packed fragment and its unsigned k-mer index
// vector from the projection extender's one-hot beat stream.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : beat handshake; in_gfm one-hot slice, in_index signed
//                       index sampled on the last beat of each pass
//   out_valid/out_ready : frame handshake
//   out_fragment      : rebuilt packed fragment
//   out_kmer_indices  : slot k holds the index of pass k
//   out_err_*         : per-frame flags (bad one-hot, pass mismatch, index range)
module proj_collapser
  import proj_pkg::*;
#(
  parameter int unsigned FRAG_LEN_BITS     = 8,
  parameter int unsigned FRAG_SIZE         = 8,
  parameter int unsigned KMER_SIZE         = 4,
  parameter int unsigned INDICES_COUNT     = 4,
  parameter int unsigned INDICE_LEN        = 3,
  parameter int unsigned SIGNED_INDICE_LEN = 4,
  parameter int unsigned FRAG_PART_ONE_HOT = 4,
  parameter int unsigned BASE_LEN          = 2,
  parameter int unsigned ONE_HOT_LEN       = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [FRAG_PART_ONE_HOT-1:0]        in_gfm,
  input  logic [SIGNED_INDICE_LEN-1:0]        in_index,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [FRAG_LEN_BITS-1:0]            out_fragment,
  output logic [INDICES_COUNT*INDICE_LEN-1:0] out_kmer_indices,
  output logic                                out_err_onehot,
  output logic                                out_err_mismatch,
  output logic                                out_err_range
);

  localparam int unsigned BPB       = FRAG_PART_ONE_HOT / ONE_HOT_LEN;
  localparam int unsigned BEAT_BITS = BASE_LEN * BPB;
  localparam int unsigned BEATS     = FRAG_LEN_BITS / BEAT_BITS;
  localparam int unsigned BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW        = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
  localparam int unsigned OFFSET    = kmer_offset(FRAG_SIZE, KMER_SIZE);
  localparam int unsigned IW        = INDICES_COUNT * INDICE_LEN;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(INDICES_COUNT - 1);

  collapser_state_t       state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [PW-1:0]          pass_q, pass_d;
  logic [FRAG_LEN_BITS-1:0] frag_q, frag_d, frag_n;
  logic [IW-1:0]          idx_q, idx_d, idx_n;
  logic                   eoh_q, eoh_d, eoh_n;
  logic                   emm_q, emm_d, emm_n;
  logic                   erg_q, erg_d, erg_n;

  logic                   ovalid_q, ovalid_d;
  logic [FRAG_LEN_BITS-1:0] ofrag_q, ofrag_d;
  logic [IW-1:0]          oidx_q, oidx_d;
  logic                   oeoh_q, oeoh_d, oemm_q, oemm_d, oerg_q, oerg_d;

  logic [BEAT_BITS-1:0]   dec_bases, stored_bits;
  logic                   dec_invalid;
  logic [SIGNED_INDICE_LEN-1:0] sum;
  logic                   accept, last_beat, last_pass, frame_done;

  gfm_base_decoder #(.BASES(BPB)) u_dec (
    .gfm_i     (in_gfm),
    .bases_o   (dec_bases),
    .invalid_o (dec_invalid)
  );

  assign in_ready   = ~ovalid_q | out_ready;
  assign accept     = in_valid & in_ready;
  assign last_beat  = (beat_q == LAST_BEAT);
  assign last_pass  = (pass_q == LAST_PASS);
  assign frame_done = last_beat & last_pass;
  assign sum        = in_index + SIGNED_INDICE_LEN'(OFFSET);

  always_comb begin
    stored_bits = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat_q == BW'(b)) stored_bits = frag_q[b*BEAT_BITS +: BEAT_BITS];
    end
  end

  // Working values including the current beat; used both for the working
  // registers and, on frame completion, for the output register load.
  always_comb begin
    frag_n = frag_q;
    idx_n  = idx_q;
    eoh_n  = eoh_q | dec_invalid;
    emm_n  = emm_q;
    erg_n  = erg_q;
    if (state_q == S_FILL) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (beat_q == BW'(b)) frag_n[b*BEAT_BITS +: BEAT_BITS] = dec_bases;
      end
    end else begin
      emm_n = emm_q | (dec_bases != stored_bits);
    end
    if (last_beat) begin
      for (int unsigned k = 0; k < INDICES_COUNT; k++) begin
        if (pass_q == PW'(k)) idx_n[k*INDICE_LEN +: INDICE_LEN] = sum[INDICE_LEN-1:0];
      end
      erg_n = erg_q | sum[SIGNED_INDICE_LEN-1];
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pass_d  = pass_q;
    frag_d  = frag_q;
    idx_d   = idx_q;
    eoh_d   = eoh_q;
    emm_d   = emm_q;
    erg_d   = erg_q;
    ovalid_d = ovalid_q & ~out_ready;
    ofrag_d  = ofrag_q;
    oidx_d   = oidx_q;
    oeoh_d   = oeoh_q;
    oemm_d   = oemm_q;
    oerg_d   = oerg_q;
    if (accept) begin
      frag_d = frag_n;
      idx_d  = idx_n;
      beat_d = last_beat ? '0 : beat_q + BW'(1);
      if (last_beat) begin
        pass_d  = last_pass ? '0 : pass_q + PW'(1);
        state_d = last_pass ? S_FILL : S_CHECK;
      end
      if (frame_done) begin
        eoh_d    = 1'b0;
        emm_d    = 1'b0;
        erg_d    = 1'b0;
        ovalid_d = 1'b1;
        ofrag_d  = frag_n;
        oidx_d   = idx_n;
        oeoh_d   = eoh_n;
        oemm_d   = emm_n;
        oerg_d   = erg_n;
      end else begin
        eoh_d = eoh_n;
        emm_d = emm_n;
        erg_d = erg_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      beat_q   <= '0;
      pass_q   <= '0;
      frag_q   <= '0;
      idx_q    <= '0;
      eoh_q    <= 1'b0;
      emm_q    <= 1'b0;
      erg_q    <= 1'b0;
      ovalid_q <= 1'b0;
      ofrag_q  <= '0;
      oidx_q   <= '0;
      oeoh_q   <= 1'b0;
      oemm_q   <= 1'b0;
      oerg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      pass_q   <= pass_d;
      frag_q   <= frag_d;
      idx_q    <= idx_d;
      eoh_q    <= eoh_d;
      emm_q    <= emm_d;
      erg_q    <= erg_d;
      ovalid_q <= ovalid_d;
      ofrag_q  <= ofrag_d;
      oidx_q   <= oidx_d;
      oeoh_q   <= oeoh_d;
      oemm_q   <= oemm_d;
      oerg_q   <= oerg_d;
    end
  end

  assign out_valid        = ovalid_q;
  assign out_fragment     = ofrag_q;
  assign out_kmer_indices = oidx_q;
  assign out_err_onehot   = oeoh_q;
  assign out_err_mismatch = oemm_q;
  assign out_err_range    = oerg_q;

endmodule

// File: tb/tb_proj_collapser.sv
// Testbench for proj_collapser: scoreboard of expected frames pushed when a
// frame's last beat is driven, compared whenever the DUT presents a frame.
module tb_proj_collapser;

  localparam int IC    = 4;
  localparam int BEATS = 4;

  typedef struct packed {
    logic [7:0]  frag;
    logic [11:0] idx;
    logic        eo;
    logic        em;
    logic        er;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_gfm;
  logic [3:0]  in_index;
  logic [7:0]  out_fragment;
  logic [11:0] out_kmer_indices;
  logic        out_err_onehot, out_err_mismatch, out_err_range;

  frame_t      exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  g_tab [IC][BEATS];
  logic [3:0]  ix_tab [IC];
  logic        pre_valid, post_valid;

  always #5 clk = ~clk;

  proj_collapser #(
    .FRAG_LEN_BITS(8), .FRAG_SIZE(8), .KMER_SIZE(4), .INDICES_COUNT(4),
    .INDICE_LEN(3), .SIGNED_INDICE_LEN(4), .FRAG_PART_ONE_HOT(4),
    .BASE_LEN(2), .ONE_HOT_LEN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_gfm(in_gfm), .in_index(in_index),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fragment(out_fragment), .out_kmer_indices(out_kmer_indices),
    .out_err_onehot(out_err_onehot), .out_err_mismatch(out_err_mismatch),
    .out_err_range(out_err_range)
  );

  function automatic void decode(input logic [3:0] c, output logic [1:0] v, output logic bad);
    case (c)
      4'b0001: begin v = 2'd0; bad = 1'b0; end
      4'b0010: begin v = 2'd1; bad = 1'b0; end
      4'b0100: begin v = 2'd2; bad = 1'b0; end
      4'b1000: begin v = 2'd3; bad = 1'b0; end
      default: begin v = 2'd0; bad = 1'b1; end
    endcase
  endfunction

  function automatic frame_t model_frame();
    frame_t     f;
    logic [1:0] v;
    logic       bad;
    logic [3:0] s;
    f = '0;
    for (int p = 0; p < IC; p++) begin
      for (int b = 0; b < BEATS; b++) begin
        decode(g_tab[p][b], v, bad);
        f.eo = f.eo | bad;
        if (p == 0) f.frag[b*2 +: 2] = v;
        else if (f.frag[b*2 +: 2] != v) f.em = 1'b1;
      end
      s = ix_tab[p] + 4'd2;
      f.idx[p*3 +: 3] = s[2:0];
      f.er = f.er | s[3];
    end
    return f;
  endfunction

  // Fragment as bases (LSB first); idxs nibble p is the signed index of pass p.
  task automatic set_frame(input logic [7:0] frag, input logic [15:0] idxs);
    logic [3:0] one;
    for (int p = 0; p < IC; p++) begin
      for (int b = 0; b < BEATS; b++) begin
        one = 4'b0001;
        g_tab[p][b] = one << frag[b*2 +: 2];
      end
      ix_tab[p] = idxs[p*4 +: 4];
    end
  endtask

  task automatic send_beat(input logic [3:0] g, input logic [3:0] ix);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_gfm   = g;
    in_index = ix;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      tests++;
      fails++;
      $display("FAIL beat_accept: in_ready=0 for 200 cycles, required 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int gap);
    frame_t f;
    int     n;
    f = model_frame();
    n = 0;
    for (int p = 0; p < IC; p++) begin
      for (int b = 0; b < BEATS; b++) begin
        if (n < nbeats) begin
          if (n == IC*BEATS-1) begin
            exp_q.push_back(f);
            pre_valid = out_valid;
          end
          send_beat(g_tab[p][b], ix_tab[p]);
          if (n == IC*BEATS-1) post_valid = out_valid;
          n++;
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
  endtask

  task automatic run_monitor();
    frame_t got;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        got = {out_fragment, out_kmer_indices, out_err_onehot, out_err_mismatch, out_err_range};
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: got frag=%h idx=%h, required no frame", got.frag, got.idx);
        end else begin
          if (got !== exp_q[0]) begin
            fails++;
            $display("FAIL frame: got frag=%h idx=%h eo=%b em=%b er=%b, required frag=%h idx=%h eo=%b em=%b er=%b",
                     got.frag, got.idx, got.eo, got.em, got.er,
                     exp_q[0].frag, exp_q[0].idx, exp_q[0].eo, exp_q[0].em, exp_q[0].er);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d frames outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_zero(input string tag);
    tests++;
    if (out_valid !== 1'b0 || out_fragment !== 8'h00 || out_kmer_indices !== 12'h000 ||
        out_err_onehot !== 1'b0 || out_err_mismatch !== 1'b0 || out_err_range !== 1'b0) begin
      fails++;
      $display("FAIL %s_outputs: got v=%b frag=%h idx=%h err=%b%b%b, required all 0", tag,
               out_valid, out_fragment, out_kmer_indices, out_err_onehot, out_err_mismatch, out_err_range);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_in_ready: got %b, required 1", tag, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_gfm    = '0;
    in_index  = '0;
    out_ready = 1'b1;
    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_frame(8'hE4, 16'h10FE);
    send_frame(16, 0);
    tests++;
    if (pre_valid !== 1'b0 || post_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency: got valid before/after last beat %b/%b, required 0/1", pre_valid, post_valid);
    end
    tests++;
    if (out_fragment !== 8'hE4 || out_kmer_indices !== 12'h688 ||
        {out_err_onehot, out_err_mismatch, out_err_range} !== 3'b000) begin
      fails++;
      $display("FAIL basic_const: got frag=%h idx=%h err=%b%b%b, required frag=e4 idx=688 err=000",
               out_fragment, out_kmer_indices, out_err_onehot, out_err_mismatch, out_err_range);
    end
    wait_drain();
  endtask

  task automatic test_onehot();
    set_frame(8'hE4, 16'h10FE);
    g_tab[0][1] = 4'b0011;
    send_frame(16, 1);
    tests++;
    if (out_fragment !== 8'hE0 || out_err_onehot !== 1'b1) begin
      fails++;
      $display("FAIL onehot: got frag=%h eo=%b, required frag=e0 eo=1", out_fragment, out_err_onehot);
    end
    wait_drain();
  endtask

  task automatic test_mismatch();
    set_frame(8'hE4, 16'h10FE);
    g_tab[2][3] = 4'b0001;
    send_frame(16, 0);
    tests++;
    if (out_fragment !== 8'hE4 || out_err_mismatch !== 1'b1 || out_err_onehot !== 1'b0) begin
      fails++;
      $display("FAIL mismatch: got frag=%h em=%b eo=%b, required frag=e4 em=1 eo=0",
               out_fragment, out_err_mismatch, out_err_onehot);
    end
    wait_drain();
  endtask

  task automatic test_range();
    logic [11:0] idx;
    set_frame(8'hE4, 16'h10FE);
    ix_tab[1] = 4'hD;
    send_frame(16, 0);
    idx = out_kmer_indices;
    tests++;
    if (idx[5:3] !== 3'b111 || out_err_range !== 1'b1) begin
      fails++;
      $display("FAIL range: got slot1=%b er=%b, required slot1=111 er=1", idx[5:3], out_err_range);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic seen;
    out_ready = 1'b0;
    fork
      begin
        set_frame(8'hE4, 16'h10FE);
        send_frame(16, 0);
        set_frame(8'h1B, 16'h0123);
        send_frame(16, 0);
      end
      begin
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        tests++;
        if (!seen) begin
          fails++;
          $display("FAIL b2b_first_frame: out_valid=0 after 200 cycles, required 1");
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_stall: got in_ready=%b, required 0", in_ready);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b1;
    set_frame(8'h4E, 16'h2310);
    send_frame(6, 0);
    #2 rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_frame(8'hE4, 16'h10FE);
    send_frame(16, 0);
    tests++;
    if (out_fragment !== 8'hE4 || out_kmer_indices !== 12'h688) begin
      fails++;
      $display("FAIL post_reset_frame: got frag=%h idx=%h, required frag=e4 idx=688",
               out_fragment, out_kmer_indices);
    end
    wait_drain();
  endtask

  initial begin
    fork
      run_monitor();
      begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000, required completion");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_basic();
    test_onehot();
    test_mismatch();
    test_range();
    test_back_to_back();
    test_reset_midframe();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
